// File: rtl/systolic_seq.sv
// systolic_seq: job sequencer driving the 2x2 systolic matmul array.
// Optional drain watchdog: define SYSTOLIC_SEQ_TIMEOUT_EN.
module systolic_seq #(
   parameter int MAX_ROWS      = 256,
   parameter int DRAIN_TIMEOUT = 64,
   localparam int RW           = $clog2(MAX_ROWS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [15:0]   cmd_w11,
   input  logic [15:0]   cmd_w12,
   input  logic [15:0]   cmd_w21,
   input  logic [15:0]   cmd_w22,
   input  logic [RW-1:0] cmd_rows,
   input  logic [1:0]    cmd_cols,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_x1,
   input  logic [15:0]   in_x2,
   output logic [15:0]   sys_data_in_1x,
   output logic [15:0]   sys_data_in_2x,
   output logic          sys_start,
   output logic [15:0]   sys_weight_in_x1,
   output logic [15:0]   sys_weight_in_x2,
   output logic          sys_accept_w_1,
   output logic          sys_accept_w_2,
   output logic          sys_switch_in,
   output logic [15:0]   ub_rd_col_size_in,
   output logic          ub_rd_col_size_valid_in,
   input  logic [15:0]   sys_data_out_x1,
   input  logic [15:0]   sys_data_out_x2,
   input  logic          sys_valid_out_x1,
   input  logic          sys_valid_out_x2,
   output logic          res_valid,
   output logic [15:0]   res_y1,
   output logic [15:0]   res_y2,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [3:0] {
      IDLE, CFG, LOAD_W0, LOAD_W1, SWITCH, STREAM, FLUSH, DRAIN, DONE
   } state_t;

   state_t        state;
   logic [15:0]   w11, w12, w21, w22;
   logic [RW-1:0] rows, acc_cnt, res_cnt;
   logic          two_cols;
   logic [15:0]   x2_skew, y1_hold;
   logic          collect, got, acc, expired;

   if (MAX_ROWS < 1 || DRAIN_TIMEOUT < 1) begin : g_bad_cfg
      $error("systolic_seq: MAX_ROWS and DRAIN_TIMEOUT must be >= 1");
   end

   // results may already appear while the tail of the job is streaming
   assign collect = (state == STREAM) || (state == FLUSH) || (state == DRAIN);
   assign got     = collect && (two_cols ? sys_valid_out_x2 : sys_valid_out_x1);
   assign acc     = (state == STREAM) && in_valid && in_ready;

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
   logic [TW-1:0] wdog;

   assign expired = (state == DRAIN) && !got && (wdog == TW'(DRAIN_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog <= '0;
         err  <= 1'b0;
      end else begin
         if (state != DRAIN || got) wdog <= '0;
         else wdog <= wdog + 1'b1;
         if (expired) err <= 1'b1;
      end
   end
`else
   assign expired = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                   <= IDLE;
         cmd_ready               <= 1'b1;
         busy                    <= 1'b0;
         done                    <= 1'b0;
         in_ready                <= 1'b0;
         w11                     <= '0;
         w12                     <= '0;
         w21                     <= '0;
         w22                     <= '0;
         rows                    <= '0;
         acc_cnt                 <= '0;
         res_cnt                 <= '0;
         two_cols                <= 1'b0;
         x2_skew                 <= '0;
         y1_hold                 <= '0;
         sys_data_in_1x          <= '0;
         sys_data_in_2x          <= '0;
         sys_start               <= 1'b0;
         sys_weight_in_x1        <= '0;
         sys_weight_in_x2        <= '0;
         sys_accept_w_1          <= 1'b0;
         sys_accept_w_2          <= 1'b0;
         sys_switch_in           <= 1'b0;
         ub_rd_col_size_in       <= '0;
         ub_rd_col_size_valid_in <= 1'b0;
         res_valid               <= 1'b0;
         res_y1                  <= '0;
         res_y2                  <= '0;
      end else begin
         ub_rd_col_size_valid_in <= 1'b0;
         ub_rd_col_size_in       <= '0;
         sys_accept_w_1          <= 1'b0;
         sys_accept_w_2          <= 1'b0;
         sys_weight_in_x1        <= '0;
         sys_weight_in_x2        <= '0;
         sys_switch_in           <= 1'b0;
         done                    <= 1'b0;

         // row 2 trails row 1 by one cycle, as the array expects
         sys_start      <= acc;
         sys_data_in_1x <= acc ? in_x1 : '0;
         sys_data_in_2x <= sys_start ? x2_skew : '0;
         if (acc) x2_skew <= in_x2;

         res_valid <= got;
         if (collect && sys_valid_out_x1) y1_hold <= sys_data_out_x1;
         if (got) begin
            res_y1  <= two_cols ? y1_hold : sys_data_out_x1;
            res_y2  <= two_cols ? sys_data_out_x2 : '0;
            res_cnt <= res_cnt + 1'b1;
         end else begin
            res_y1 <= '0;
            res_y2 <= '0;
         end

         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  w11       <= cmd_w11;
                  w12       <= cmd_w12;
                  w21       <= cmd_w21;
                  w22       <= cmd_w22;
                  rows      <= (cmd_rows == '0) ? RW'(1) : cmd_rows;
                  two_cols  <= (cmd_cols >= 2'd2);
                  acc_cnt   <= '0;
                  res_cnt   <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  ub_rd_col_size_valid_in <= 1'b1;
                  ub_rd_col_size_in <= (cmd_cols >= 2'd2) ? 16'd2 : 16'd1;
                  state     <= CFG;
               end
            end
            CFG: begin
               sys_accept_w_1   <= 1'b1;
               sys_accept_w_2   <= 1'b1;
               sys_weight_in_x1 <= w21;
               sys_weight_in_x2 <= w22;
               state            <= LOAD_W0;
            end
            LOAD_W0: begin
               sys_accept_w_1   <= 1'b1;
               sys_accept_w_2   <= 1'b1;
               sys_weight_in_x1 <= w11;
               sys_weight_in_x2 <= w12;
               state            <= LOAD_W1;
            end
            LOAD_W1: begin
               sys_switch_in <= 1'b1;
               state         <= SWITCH;
            end
            SWITCH: begin
               in_ready <= 1'b1;
               state    <= STREAM;
            end
            STREAM: begin
               if (acc) begin
                  acc_cnt <= acc_cnt + 1'b1;
                  if (acc_cnt + 1'b1 == rows) begin
                     in_ready <= 1'b0;
                     state    <= FLUSH;
                  end
               end
            end
            FLUSH: state <= DRAIN;
            DRAIN: begin
               if (res_cnt == rows || expired) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: scoreboard bench for systolic_seq with a small
// behavioural 2x2 array on the north, west and south edges.
`timescale 1ns/1ps
module tb_systolic_seq;
   localparam int RW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [15:0]   cmd_w11 = '0, cmd_w12 = '0, cmd_w21 = '0, cmd_w22 = '0;
   logic [RW-1:0] cmd_rows = '0;
   logic [1:0]    cmd_cols = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_x1 = '0, in_x2 = '0;
   logic [15:0]   sys_data_in_1x, sys_data_in_2x;
   logic          sys_start;
   logic [15:0]   sys_weight_in_x1, sys_weight_in_x2;
   logic          sys_accept_w_1, sys_accept_w_2, sys_switch_in;
   logic [15:0]   ub_rd_col_size_in;
   logic          ub_rd_col_size_valid_in;
   logic [15:0]   sys_data_out_x1, sys_data_out_x2;
   logic          sys_valid_out_x1, sys_valid_out_x2;
   logic          res_valid;
   logic [15:0]   res_y1, res_y2;
   logic          busy, done, err;

   always #5 clk = ~clk;

   systolic_seq #(.MAX_ROWS(256), .DRAIN_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_w11(cmd_w11), .cmd_w12(cmd_w12),
      .cmd_w21(cmd_w21), .cmd_w22(cmd_w22),
      .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x1(in_x1), .in_x2(in_x2),
      .sys_data_in_1x(sys_data_in_1x), .sys_data_in_2x(sys_data_in_2x),
      .sys_start(sys_start),
      .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
      .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
      .sys_switch_in(sys_switch_in),
      .ub_rd_col_size_in(ub_rd_col_size_in),
      .ub_rd_col_size_valid_in(ub_rd_col_size_valid_in),
      .sys_data_out_x1(sys_data_out_x1), .sys_data_out_x2(sys_data_out_x2),
      .sys_valid_out_x1(sys_valid_out_x1), .sys_valid_out_x2(sys_valid_out_x2),
      .res_valid(res_valid), .res_y1(res_y1), .res_y2(res_y2),
      .busy(busy), .done(done), .err(err)
   );

   // array model: shadow/active weights, row-2 one cycle behind row 1
   logic [15:0] s11, s21, s12, s22, a11, a21, a12, a22;
   logic        p_v, d_v, v2;
   logic [15:0] p_x1, d_y1, d_y2, q_y2;
   bit          mute = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s11 <= '0; s21 <= '0; s12 <= '0; s22 <= '0;
         a11 <= '0; a21 <= '0; a12 <= '0; a22 <= '0;
         p_v <= 1'b0; d_v <= 1'b0; v2 <= 1'b0;
         p_x1 <= '0; d_y1 <= '0; d_y2 <= '0; q_y2 <= '0;
         sys_valid_out_x1 <= 1'b0; sys_valid_out_x2 <= 1'b0;
         sys_data_out_x1 <= '0; sys_data_out_x2 <= '0;
      end else begin
         if (sys_accept_w_1) begin s21 <= s11; s11 <= sys_weight_in_x1; end
         if (sys_accept_w_2) begin s22 <= s12; s12 <= sys_weight_in_x2; end
         if (sys_switch_in) begin
            a11 <= s11; a21 <= s21; a12 <= s12; a22 <= s22;
         end
         p_v  <= sys_start;
         p_x1 <= sys_data_in_1x;
         d_v  <= p_v;
         d_y1 <= p_x1 * a11 + sys_data_in_2x * a21;
         d_y2 <= p_x1 * a12 + sys_data_in_2x * a22;
         sys_valid_out_x1 <= d_v && !mute;
         sys_data_out_x1  <= d_y1;
         v2   <= d_v && !mute;
         q_y2 <= d_y2;
         sys_valid_out_x2 <= v2;
         sys_data_out_x2  <= q_y2;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] exp_q[$];
   logic [31:0] e_pop;
   int   n_done = 0, n_res = 0, last_res = 0, done_at = 0;
   int   aw_cnt = 0, sw_cnt = 0, st_runs = 0;
   logic st_prev = 1'b0;

   always @(negedge clk) begin
      if (res_valid) begin
         n_res++;
         last_res = cyc;
         if (exp_q.size() == 0) check("res_extra", 32'(exp_q.size()), 1);
         else begin
            e_pop = exp_q.pop_front();
            check("res", {res_y1, res_y2}, e_pop);
         end
      end
      if (done) begin n_done++; done_at = cyc; end
      if (sys_accept_w_1) aw_cnt++;
      if (sys_switch_in) sw_cnt++;
      if (sys_start && !st_prev) st_runs++;
      st_prev = sys_start;
   end

   int          acc_at = 0, last_acc = 0, lat0 = 0, k = 0;
   logic [15:0] vx1[4], vx2[4];

   task automatic run_job(input logic [15:0] w11, w12, w21, w22,
                          input int rows, input int feed,
                          input logic [1:0] cols, input bit gap,
                          input bit finish);
      int t;
      bit two;
      logic [15:0] y1, y2;
      two = (cols >= 2'd2);
      aw_cnt = 0; sw_cnt = 0; st_runs = 0; n_done = 0;
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_w11 = w11; cmd_w12 = w12; cmd_w21 = w21; cmd_w22 = w22;
      cmd_rows = RW'(rows); cmd_cols = cols;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      acc_at = cyc;
      @(negedge clk);
      check("cfg_strobe", 32'(ub_rd_col_size_valid_in), 1);
      check("cfg_cols", 32'(ub_rd_col_size_in), two ? 2 : 1);
      @(negedge clk);
      check("w_first", {sys_weight_in_x1, sys_weight_in_x2}, {w21, w22});
      @(negedge clk);
      check("w_second", {sys_weight_in_x1, sys_weight_in_x2}, {w11, w12});
      @(negedge clk);
      check("switch", 32'({sys_switch_in, sys_accept_w_1, sys_accept_w_2}), 4);
      for (int i = 0; i < feed; i++) begin
         in_valid = 1'b1; in_x1 = vx1[i]; in_x2 = vx2[i];
         t = 0;
         while (!in_ready && t < 20) begin @(negedge clk); t++; end
         if (!in_ready) begin
            check("in_ready_wait", 32'(in_ready), 1);
            break;
         end
         @(posedge clk);
         #1 last_acc = cyc;
         y1 = vx1[i] * w11 + vx2[i] * w21;
         y2 = two ? vx1[i] * w12 + vx2[i] * w22 : 16'd0;
         if (!mute) exp_q.push_back({y1, y2});
         @(negedge clk);
         if (gap && i == 0) begin in_valid = 1'b0; @(negedge clk); end
      end
      in_valid = 1'b0;
      if (!finish) return;
      check("in_ready_low", 32'(in_ready), 0);
      t = 0;
      while (n_done == 0 && t < 100) begin @(negedge clk); t++; end
      check("done_seen", 32'(n_done), 1);
      if (!mute) check("done_lag", 32'(done_at - last_res), 1);
      @(negedge clk);
      @(negedge clk);
      check("done_pulse", 32'(n_done), 1);
      check("sb_empty", 32'(exp_q.size()), 0);
      check("accept_w_cycles", 32'(aw_cnt), 2);
      check("switch_cycles", 32'(sw_cnt), 1);
      check("start_runs", 32'(st_runs), gap ? 2 : 1);
      check("idle_ready", 32'({cmd_ready, busy}), 2);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ctrl", 32'({cmd_ready, busy, done, in_ready, res_valid,
            sys_start, sys_switch_in, sys_accept_w_1, sys_accept_w_2,
            ub_rd_col_size_valid_in, err}), 32'h400);
      check("rst_data", {sys_data_in_1x, sys_weight_in_x1}, 0);
      rst = 1'b0;
      @(negedge clk);

      // identity weights, single vector
      vx1[0] = 16'd3; vx2[0] = 16'd5;
      run_job(16'd1, 16'd0, 16'd0, 16'd1, 1, 1, 2'd2, 1'b0, 1'b1);

      // all-2 weights, back-to-back vectors
      vx1[0] = 16'd1; vx2[0] = 16'd1;
      vx1[1] = 16'd2; vx2[1] = 16'd0;
      vx1[2] = 16'd0; vx2[2] = 16'd4;
      run_job(16'd2, 16'd2, 16'd2, 16'd2, 3, 3, 2'd2, 1'b0, 1'b1);
      lat0 = done_at - acc_at;

      // same job with one bubble
      run_job(16'd2, 16'd2, 16'd2, 16'd2, 3, 3, 2'd2, 1'b1, 1'b1);
      check("gap_latency", 32'(done_at - acc_at), 32'(lat0 + 1));

      // single column
      vx1[0] = 16'd1; vx2[0] = 16'd2;
      vx1[1] = 16'd2; vx2[1] = 16'd0;
      run_job(16'd3, 16'd7, 16'd1, 16'd9, 2, 2, 2'd1, 1'b0, 1'b1);

      // rows=0 runs one vector, cols=3 runs two columns
      vx1[0] = 16'd5; vx2[0] = 16'd6;
      run_job(16'd1, 16'd2, 16'd3, 16'd4, 0, 1, 2'd3, 1'b0, 1'b1);

      // abort in the middle of streaming
      vx1[0] = 16'd1; vx2[0] = 16'd1;
      vx1[1] = 16'd2; vx2[1] = 16'd2;
      run_job(16'd1, 16'd1, 16'd1, 16'd1, 4, 2, 2'd2, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("abort_ctrl", 32'({cmd_ready, busy, done, in_ready, res_valid,
            sys_start, sys_switch_in, sys_accept_w_1, sys_accept_w_2,
            ub_rd_col_size_valid_in, err}), 32'h400);
      check("abort_data", {sys_data_in_1x, sys_data_in_2x}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      k = n_res;
      repeat (10) @(negedge clk);
      check("abort_no_done", 32'(n_done), 0);
      check("abort_no_res", 32'(n_res - k), 0);

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
      mute = 1'b1;
      vx1[0] = 16'd1; vx2[0] = 16'd1;
      run_job(16'd1, 16'd1, 16'd1, 16'd1, 1, 1, 2'd2, 1'b0, 1'b1);
      check("to_lag", 32'(done_at - last_acc), 9);
      check("err_set", 32'(err), 1);
      repeat (3) @(negedge clk);
      check("err_sticky", 32'(err), 1);
      rst = 1'b1;
      #1;
      check("err_clear", 32'(err), 0);
      @(negedge clk);
      rst = 1'b0;
`else
      check("err_tied", 32'(err), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
Sequencer for the 2x2 systolic matmul array. It accepts one job command carrying four weights, a row count and a column size, and runs the job in order:
- configures the enabled columns
- shifts weights down both columns
- pulses the switch
- streams input vectors with row skew
- collects and deskews column results into one result stream

It sits between the unified-buffer/host side and the systolic array, and is the only driver of the array's control inputs.

Parameters:
MAX_ROWS, 256, maximum input vectors per job; sets the row counter width to clog2(MAX_ROWS+1).
DRAIN_TIMEOUT, 64, cycles allowed in DRAIN without a result before the error (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  job command valid
cmd_ready  out  1  high only in IDLE
cmd_w11, cmd_w12, cmd_w21, cmd_w22  in  16 each  weight for row r, column c
cmd_rows  in  clog2(MAX_ROWS+1)  number of input vectors, 1..MAX_ROWS
cmd_cols  in  2  enabled columns, 1..2
in_valid  in  1  input vector valid
in_ready  out  1  sequencer accepts the vector this cycle
in_x1, in_x2  in  16 each  row-1 and row-2 elements of the vector
sys_data_in_1x, sys_data_in_2x  out  16 each  to array west edge
sys_start  out  1  row-1 input valid to array
sys_weight_in_x1, sys_weight_in_x2  out  16 each  to array north edge
sys_accept_w_1, sys_accept_w_2  out  1 each  weight shift enable per column
sys_switch_in  out  1  shadow-to-active weight copy pulse
ub_rd_col_size_in  out  16  column count to array
ub_rd_col_size_valid_in  out  1  column-count load strobe
sys_data_out_x1, sys_data_out_x2  in  16 each  array south outputs
sys_valid_out_x1, sys_valid_out_x2  in  1 each  array output valids
res_valid  out  1  deskewed result pair valid (pulse, no backpressure)
res_y1, res_y2  out  16 each  column-1 and column-2 results
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
err  out  1  sticky drain timeout (optional feature only; 0 otherwise)

Behaviour:
- Reset: every output is 0 except cmd_ready=1. State is IDLE and all counters are 0. Reset mid-job aborts immediately; no done pulse is produced.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch all cmd_* fields, then go to CFG.
  - cmd_rows=0 is treated as 1; cmd_cols=0 is treated as 1, cmd_cols=3 as 2.
- CFG (1 cycle):
  - ub_rd_col_size_valid_in=1, with ub_rd_col_size_in = latched cols, zero-extended.
  - Go to LOAD_W.
- LOAD_W (2 cycles):
  - Cycle 0: sys_weight_in_x1=w21, sys_weight_in_x2=w22.
  - Cycle 1: sys_weight_in_x1=w11, sys_weight_in_x2=w12.
  - sys_accept_w_1=1 and sys_accept_w_2=1 in both cycles; weight outputs return to 0 afterwards.
  - Go to SWITCH.
- SWITCH (1 cycle): sys_switch_in=1. Go to STREAM.
- STREAM:
  - in_ready=1 while accepted count < rows.
  - On an in_valid&&in_ready handshake: sys_data_in_1x=in_x1, sys_start=1. in_x2 is registered and presented on sys_data_in_2x the next cycle, matching the array's internal one-cycle valid skew.
  - No handshake: sys_start=0, sys_data_in_1x=0. Bubbles are legal and propagate as invalid.
  - After the last accept, spend one more cycle to flush the row-2 skew register, then go to DRAIN.
- DRAIN:
  - sys_valid_out_x1 registers sys_data_out_x1 into a hold register.
  - sys_valid_out_x2 produces, next cycle: res_valid=1, res_y1=hold, res_y2=sys_data_out_x2.
  - When cols=1: emit on sys_valid_out_x1 directly (registered, 1-cycle latency), with res_y2=0.
  - Result pairs are counted, including any emitted during STREAM. When the count reaches rows, go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Minimum job latency from cmd accept to done: 1 (CFG) + 2 (LOAD_W) + 1 (SWITCH) + rows + 1 (skew flush) + array drain + 1 (DONE).
- All sequencer outputs are registered. The array is never stalled; result consumers must sink res_valid every cycle.

Optional Feature:
- Macro SYSTOLIC_SEQ_TIMEOUT_EN.
- Defined: a counter resets on every result and increments each cycle in DRAIN. On reaching DRAIN_TIMEOUT, err is set (sticky until rst) and the FSM goes to DONE, still pulsing done.
- Undefined: no counter, err is tied 0, and DRAIN waits indefinitely.

Test Plan:
- Reset mid-STREAM with rows=4 after 2 accepts -> all outputs reset, cmd_ready=1, no done pulse.
- Weights w11=1,w12=0,w21=0,w22=1, cols=2, rows=1, x=(3,5) -> accept_w high exactly 2 cycles, switch 1 cycle after; single res_valid with (3,5); done 1 cycle later.
- Weights all 2, rows=3, vectors (1,1),(2,0),(0,4), in_valid held high -> three res_valid pulses (4,4),(4,4),(8,8) in order; in_ready low after the third accept.
- Same job with in_valid deasserted one cycle between vectors -> sys_start shows a bubble; results identical, done arrives 1 cycle later.
- cols=1, rows=2, w11=3, w21=1, x=(1,2),(2,0) -> ub_rd_col_size_in=1 strobed in CFG; res_y1=5 then 6, res_y2=0.
- With SYSTOLIC_SEQ_TIMEOUT_EN and DRAIN_TIMEOUT=8, array valids forced low -> err=1 and done pulse exactly 8 cycles after entering DRAIN.
